// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core LSU
// (port 0) and the DMA/debug port (port 1). It grants requests round-robin
// and keeps one request in flight at a time. Byte-masked stores become a
// read followed by a merged write, because the memory has no byte enables.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [BE_WIDTH-1:0]   req0_be,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [BE_WIDTH-1:0]   req1_be,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RMW_MERGE = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    localparam logic [BE_WIDTH-1:0] BE_ALL  = {BE_WIDTH{1'b1}};
    localparam logic [BE_WIDTH-1:0] BE_NONE = {BE_WIDTH{1'b0}};

    // Byte i of the result comes from new_d when be[i] is set, else from old_d.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_d,
        input logic [DATA_WIDTH-1:0] old_d,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] m;
        m = old_d;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                m[i*8 +: 8] = new_d[i*8 +: 8];
            end else begin
                m[i*8 +: 8] = old_d[i*8 +: 8];
            end
        end
        return m;
    endfunction

    state_t                state_r;
    logic                  last_grant_r;
    logic                  id_r;
    logic                  write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [BE_WIDTH-1:0]   be_r;

    logic                  any_valid_s;
    logic                  grant_s;
    logic                  sel_write_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [BE_WIDTH-1:0]   sel_be_s;
    logic                  accept_s;
    logic                  partial_s;

    // Pick the winning port and mux its request fields.
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
        sel_write_s = grant_s ? req1_write : req0_write;
        sel_addr_s  = grant_s ? req1_addr  : req0_addr;
        sel_wdata_s = grant_s ? req1_wdata : req0_wdata;
        sel_be_s    = grant_s ? req1_be    : req0_be;
        partial_s   = sel_write_s && (sel_be_s != BE_ALL) && (sel_be_s != BE_NONE);
        accept_s    = rst_n && (state_r == ST_IDLE) && any_valid_s;
    end

    // Sequencer: latch the accepted request and walk IDLE -> (RMW_MERGE) -> RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            write_r      <= 1'b0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            be_r         <= BE_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= grant_s;
                        id_r         <= grant_s;
                        write_r      <= sel_write_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        be_r         <= sel_be_s;
                        state_r      <= partial_s ? ST_RMW_MERGE : ST_RESP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RMW_MERGE: state_r <= ST_RESP;
                ST_RESP:      state_r <= ST_IDLE;
                default:      state_r <= ST_IDLE;
            endcase
        end
    end

    // Handshake, memory strobes and response pulses; all held low in reset.
    always_comb begin
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        rsp0_valid     = 1'b0;
        rsp1_valid     = 1'b0;
        rsp0_rdata     = {DATA_WIDTH{1'b0}};
        rsp1_rdata     = {DATA_WIDTH{1'b0}};
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = {ADDR_WIDTH{1'b0}};
        mem_write_data = {DATA_WIDTH{1'b0}};
        if (!rst_n) begin
            mem_read = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        req0_ready  = ~grant_s;
                        req1_ready  = grant_s;
                        mem_address = sel_addr_s;
                        if (!sel_write_s) begin
                            mem_read = 1'b1;
                        end else if (sel_be_s == BE_ALL) begin
                            mem_write      = 1'b1;
                            mem_write_data = sel_wdata_s;
                        end else if (sel_be_s == BE_NONE) begin
                            mem_read = 1'b0;
                        end else begin
                            mem_read = 1'b1;
                        end
                    end else begin
                        mem_read = 1'b0;
                    end
                end
                ST_RMW_MERGE: begin
                    mem_write      = 1'b1;
                    mem_address    = addr_r;
                    mem_write_data = merge_bytes(wdata_r, mem_read_data, be_r);
                end
                ST_RESP: begin
                    if (id_r) begin
                        rsp1_valid = 1'b1;
                        rsp1_rdata = write_r ? {DATA_WIDTH{1'b0}} : mem_read_data;
                    end else begin
                        rsp0_valid = 1'b1;
                        rsp0_rdata = write_r ? {DATA_WIDTH{1'b0}} : mem_read_data;
                    end
                end
                default: begin
                    mem_read = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural memory, directed stimulus with
// hand-computed expectations pushed to a scoreboard, and a monitor that
// pops and compares on every response pulse.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_write;
    logic [9:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_be;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [9:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_be;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        mem_read, mem_write;
    logic [9:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
        if (mem_read)  mem_read_data <= mem[mem_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: compare every response pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("strobe_excl", 64'(mem_read & mem_write), 64'd0);
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", 64'({rsp1_valid, rsp0_valid}), e.port ? 64'd2 : 64'd1);
                    check("rsp_data", 64'(e.port ? rsp1_rdata : rsp0_rdata), 64'(e.data));
                end
            end
        end
    end

    task automatic drive(input logic port, input logic wr, input logic [9:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (port) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = wd; req1_be = be;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = wd; req0_be = be;
        end
    endtask

    // One request from an idle arbiter; strobe = {mem_read, mem_write} in the accept cycle.
    task automatic single(input string name, input logic port, input logic wr,
                          input logic [9:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic [1:0] strobe, input logic partial,
                          input logic [31:0] merged, input logic [31:0] rdata);
        @(negedge clk);
        drive(port, wr, a, wd, be);
        #1;
        check({name, "_ready"}, 64'({req1_ready, req0_ready}), port ? 64'd2 : 64'd1);
        check({name, "_strobe"}, 64'({mem_read, mem_write}), 64'(strobe));
        if (strobe != 2'b00) check({name, "_addr"}, 64'(mem_address), 64'(a));
        if (strobe == 2'b01) check({name, "_wdata"}, 64'(mem_write_data), 64'(wd));
        push(port, rdata);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (partial) begin
            @(negedge clk);
            #1;
            check({name, "_rmw_strobe"}, 64'({mem_read, mem_write}), 64'd1);
            check({name, "_rmw_addr"}, 64'(mem_address), 64'(a));
            check({name, "_rmw_data"}, 64'(mem_write_data), 64'(merged));
            check({name, "_rmw_norsp"}, 64'({rsp1_valid, rsp0_valid}), 64'd0);
        end
        @(negedge clk);
        #1;
        check({name, "_rsp_when"}, 64'({rsp1_valid, rsp0_valid}), port ? 64'd2 : 64'd1);
        check({name, "_rsp_ready"}, 64'({req1_ready, req0_ready}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 10'd0; req0_wdata = 32'd0; req0_be = 4'd0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 10'd0; req1_wdata = 32'd0; req1_be = 4'd0;
        for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        mem[10'h100] <= 32'hA0A0_0100;
        mem[10'h200] <= 32'hB0B0_0200;
        mem[10'h005] <= 32'hDEAD_BEEF;
        mem[10'h020] <= 32'h1122_3344;
        mem[10'h030] <= 32'h0000_0055;

        // Reset with both ports requesting loads.
        drive(1'b0, 1'b0, 10'h100, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 10'h200, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_outputs", 64'({req1_ready, req0_ready, rsp1_valid, rsp0_valid, mem_read, mem_write}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("first_grant", 64'({req1_ready, req0_ready}), 64'd1);
        check("first_read", 64'({mem_read, mem_write}), 64'd2);
        push(1'b0, 32'hA0A0_0100);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        #1 check("resp_no_ready", 64'({req1_ready, req0_ready}), 64'd0);
        @(negedge clk);
        #1 check("second_grant", 64'({req1_ready, req0_ready}), 64'd2);
        push(1'b1, 32'hB0B0_0200);
        @(posedge clk);
        #1 req0_valid = 1'b1;
        @(negedge clk);
        #1 check("resp_no_ready2", 64'({req1_ready, req0_ready}), 64'd0);

        // Contention: both hold loads, grants alternate 0,1,0,1 every 2 cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("rr_grant", 64'({req1_ready, req0_ready}), (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i % 2 == 0) push(1'b0, 32'hA0A0_0100);
            else            push(1'b1, 32'hB0B0_0200);
            @(negedge clk);
            #1 check("rr_gap", 64'({req1_ready, req0_ready}), 64'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Plain load.
        single("load", 1'b0, 1'b0, 10'h005, 32'd0, 4'b0000, 2'b10, 1'b0, 32'd0, 32'hDEAD_BEEF);
        // Partial store -> read-modify-write.
        single("partial", 1'b1, 1'b1, 10'h020, 32'h0000_AB00, 4'b0010, 2'b10, 1'b1,
               32'h1122_AB44, 32'd0);
        @(negedge clk);
        check("partial_mem", 64'(mem[10'h020]), 64'h1122_AB44);
        // Empty store: no strobe, memory untouched.
        single("empty", 1'b0, 1'b1, 10'h030, 32'hFFFF_FFFF, 4'b0000, 2'b00, 1'b0, 32'd0, 32'd0);
        check("empty_mem", 64'(mem[10'h030]), 64'h55);
        // Full store and readback.
        single("full", 1'b0, 1'b1, 10'h031, 32'hCAFE_F00D, 4'b1111, 2'b01, 1'b0, 32'd0, 32'd0);
        single("readback", 1'b1, 1'b0, 10'h031, 32'd0, 4'b0000, 2'b10, 1'b0, 32'd0, 32'hCAFE_F00D);

        // Reset in RMW_MERGE: no write, no response, memory unchanged.
        @(negedge clk);
        mem[10'h020] <= 32'h1122_3344;
        drive(1'b1, 1'b1, 10'h020, 32'h0000_AB00, 4'b0010);
        #1 check("abort_ready", 64'({req1_ready, req0_ready}), 64'd2);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_outputs", 64'({mem_read, mem_write, rsp1_valid, rsp0_valid}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("abort_mem", 64'(mem[10'h020]), 64'h1122_3344);
        rst_n = 1'b1;

        // First access after reset behaves like power-up: port 0 wins a tie.
        @(negedge clk);
        drive(1'b0, 1'b0, 10'h020, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 10'h031, 32'd0, 4'd0);
        #1 check("post_rst_grant", 64'({req1_ready, req0_ready}), 64'd1);
        push(1'b0, 32'h1122_3344);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("post_rst_grant2", 64'({req1_ready, req0_ready}), 64'd2);
        push(1'b1, 32'hCAFE_F00D);
        @(posedge clk);
        #1 req1_valid = 1'b0;

        repeat (3) @(negedge clk);
        #1 check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
